// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deals two cards each, runs player hit/stand, dealer
// draw-to-threshold, and scores the round. Totals and result are registered.
module blackjack_round_ctrl #(
    parameter int DEALER_STAND = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit_pressed,
    input  logic       stand_pressed,
    input  logic       deal_pressed,
    output logic       card_req,
    input  logic       card_valid,
    input  logic [3:0] card_value,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic [1:0] result,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        PLAYER  = 4'd5,
        P_DRAW  = 4'd6,
        DEALER  = 4'd7,
        D_DRAW  = 4'd8,
        RESULT  = 4'd9
    } state_t;

    localparam logic [5:0] STAND_T = 6'(DEALER_STAND);

    state_t     cur, nxt;
    logic [4:0] p_hard, d_hard, p_hard_n, d_hard_n;
    logic       p_ace, d_ace, p_ace_n, d_ace_n;
    logic [1:0] result_n;
    logic       accept;

    function automatic logic [4:0] card_points(input logic [3:0] v);
        return (v == 4'd0 || v > 4'd10) ? 5'd10 : {1'b0, v};
    endfunction

    function automatic logic [4:0] sat_add(input logic [4:0] h, input logic [4:0] p);
        logic [5:0] s;
        s = {1'b0, h} + {1'b0, p};
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    // An ace is promoted to 11 only when that keeps the hand at or under 21.
    function automatic logic [4:0] best_total(input logic [4:0] h, input logic a);
        return (a && h <= 5'd11) ? h + 5'd10 : h;
    endfunction

    always_comb begin
        card_req = (cur == DEAL_P1) || (cur == DEAL_D1) || (cur == DEAL_P2) ||
                   (cur == DEAL_D2) || (cur == P_DRAW)  || (cur == D_DRAW);
    end

    assign accept = card_req && card_valid;
    assign state  = cur;

    always_comb begin
        nxt      = cur;
        p_hard_n = p_hard;
        d_hard_n = d_hard;
        p_ace_n  = p_ace;
        d_ace_n  = d_ace;
        result_n = result;
        case (cur)
            IDLE, RESULT: begin
                if (deal_pressed) begin
                    p_hard_n = 5'd0;
                    d_hard_n = 5'd0;
                    p_ace_n  = 1'b0;
                    d_ace_n  = 1'b0;
                    result_n = 2'b00;
                    nxt      = DEAL_P1;
                end
            end
            DEAL_P1, DEAL_P2, P_DRAW: begin
                if (accept) begin
                    p_hard_n = sat_add(p_hard, card_points(card_value));
                    p_ace_n  = p_ace || (card_value == 4'd1);
                    if (cur == DEAL_P1) begin
                        nxt = DEAL_D1;
                    end else if (cur == DEAL_P2) begin
                        nxt = DEAL_D2;
                    end else if (best_total(p_hard_n, p_ace_n) > 5'd21) begin
                        nxt      = RESULT;
                        result_n = 2'b10;
                    end else begin
                        nxt = PLAYER;
                    end
                end
            end
            DEAL_D1, DEAL_D2, D_DRAW: begin
                if (accept) begin
                    d_hard_n = sat_add(d_hard, card_points(card_value));
                    d_ace_n  = d_ace || (card_value == 4'd1);
                    nxt      = (cur == DEAL_D1) ? DEAL_P2 :
                               (cur == DEAL_D2) ? PLAYER  : DEALER;
                end
            end
            PLAYER: begin
                if (stand_pressed) begin
                    nxt = DEALER;
                end else if (hit_pressed) begin
                    nxt = P_DRAW;
                end
            end
            DEALER: begin
                if ({1'b0, dealer_total} < STAND_T) begin
                    nxt = D_DRAW;
                end else begin
                    nxt = RESULT;
                    if (dealer_total > 5'd21)             result_n = 2'b01;
                    else if (player_total > dealer_total) result_n = 2'b01;
                    else if (player_total < dealer_total) result_n = 2'b10;
                    else                                  result_n = 2'b11;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cur          <= IDLE;
            p_hard       <= 5'd0;
            d_hard       <= 5'd0;
            p_ace        <= 1'b0;
            d_ace        <= 1'b0;
            player_total <= 5'd0;
            dealer_total <= 5'd0;
            result       <= 2'b00;
        end else begin
            cur          <= nxt;
            p_hard       <= p_hard_n;
            d_hard       <= d_hard_n;
            p_ace        <= p_ace_n;
            d_ace        <= d_ace_n;
            player_total <= best_total(p_hard_n, p_ace_n);
            dealer_total <= best_total(d_hard_n, d_ace_n);
            result       <= result_n;
        end
    end

endmodule

// File: doc/blackjack_round_ctrl.md
BLACKJACK_ROUND_CTRL -- requirements
Module: blackjack_round_ctrl

Interface
REQ-001 SHALL have parameter DEALER_STAND, default 17, the dealer's best total at or above which the dealer stops drawing.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-high (asserted = 1).
REQ-004 SHALL have port hit_pressed, input, 1, a one-cycle debounced pulse meaning "player hits".
REQ-005 SHALL have port stand_pressed, input, 1, a one-cycle debounced pulse meaning "player stands".
REQ-006 SHALL have port deal_pressed, input, 1, a one-cycle debounced pulse meaning "start round".
REQ-007 SHALL have port card_req, output, 1, high while a card is wanted from the card source.
REQ-008 SHALL have port card_valid, input, 1, the card source's flag that card_value is valid this cycle.
REQ-009 SHALL have port card_value, input, 4, the card rank: 1 = ace, 2-10 = pip value, 11-13 = face card.
REQ-010 SHALL have port player_total, output, 5, the player's best hand total.
REQ-011 SHALL have port dealer_total, output, 5, the dealer's best hand total.
REQ-012 SHALL have port result, output, 2, the round outcome: 00 = none, 01 = player wins, 10 = dealer wins, 11 = push.
REQ-013 SHALL have port state, output, 4, the current FSM state encoding, for display and debug.

Function
REQ-014 SHALL implement these FSM states: IDLE=0, DEAL_P1=1, DEAL_D1=2, DEAL_P2=3, DEAL_D2=4, PLAYER=5, P_DRAW=6, DEALER=7, D_DRAW=8, RESULT=9.
REQ-015 SHALL drive card_req high exactly when the state is DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, P_DRAW or D_DRAW.
REQ-016 SHALL accept a card only in a cycle with card_req=1 and card_valid=1; card_valid while card_req=0 SHALL be ignored.
REQ-017 SHALL apply the accepted card to the hand on the same edge as the state advance; one card per accepting cycle.
REQ-018 SHALL map card values: 11-15 count as 10, 0 counts as 10, 1 counts as 1 and increments the ace flag for that hand.
REQ-019 SHALL keep a per-hand hard sum, saturating at 31, plus an ace-present bit.
REQ-020 SHALL compute best total = hard+10 if ace present and hard+10 <= 21, else hard; this value is what player_total and dealer_total show.
REQ-021 In IDLE or RESULT, deal_pressed SHALL clear both hands and result and go to DEAL_P1; deal_pressed in any other state SHALL be ignored.
REQ-022 The deal sequence SHALL be DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> PLAYER, each step advancing on card acceptance.
REQ-023 In PLAYER, stand_pressed -> DEALER and hit_pressed -> P_DRAW; if both pulse in the same cycle, stand SHALL win.
REQ-024 hit_pressed and stand_pressed outside PLAYER SHALL be ignored.
REQ-025 On acceptance in P_DRAW, if the new player best total > 21 the FSM SHALL go to RESULT with result=10; otherwise it SHALL return to PLAYER.
REQ-026 In DEALER, dealer best < DEALER_STAND -> D_DRAW, else -> RESULT, with the transition taken one cycle after entry.
REQ-027 On acceptance in D_DRAW the FSM SHALL return to DEALER.
REQ-028 On entry to RESULT from DEALER, result SHALL be set as follows: dealer > 21 -> 01; player > dealer -> 01; player < dealer -> 10; equal -> 11.
REQ-029 result SHALL hold its value through RESULT until the next deal_pressed or reset.
REQ-030 All outputs SHALL be registered except card_req, which SHALL be decoded from state only.

Reset
REQ-031 When rst_n is asserted the block SHALL immediately set state=IDLE, card_req=0, player_total=0, dealer_total=0, result=00, and clear both ace flags, regardless of the current state.
REQ-032 A reset asserted mid-draw SHALL abandon the pending card; a card_valid arriving during or after reset SHALL NOT be applied.

Verification
REQ-033 Reset, then deal_pressed, then cards 10, 9, 1, 7 -> state=PLAYER, player_total=21 (soft), dealer_total=16.
REQ-034 From the REQ-033 state, stand_pressed, then dealer receives card 5 -> dealer_total=21, result=11 (push), state=RESULT.
REQ-035 Deal with cards 10, 5, 6, 10, then hit with card 9 -> player_total=25, result=10, state=RESULT, with no dealer draw.
REQ-036 Hit and stand pulsed in the same cycle in PLAYER -> state=DEALER and card_req stays 0 for that transition.
REQ-037 card_valid=1 held in IDLE, then deal_pressed with card_valid stalled low for 5 cycles -> totals do not change until card_valid returns, and card_req stays 1.
REQ-038 Reset pulsed while in D_DRAW with card_valid=1 -> state=IDLE, all outputs 0, card not applied; a subsequent deal starts a clean round.
